// File: rtl/branch_pred_update_ctrl.sv
// -----------------------------------------------------------------------------
// branch_pred_update_ctrl
//
// Schedules all writes into the branch predictor (BTB + BHT). Resolved-branch
// updates from execute are buffered in a small FIFO and drained one per cycle
// whenever the predictor write port is free. A flush sequencer walks every
// predictor set index and clears it (fence.i / context switch). This block is
// the only driver of the predictor write side.
//
// Ports:
//   i_clk, i_arst          clock, synchronous active-high reset
//   i_upd_*                resolved update from execute (valid/taken/way/pc/target)
//   o_upd_ready            FIFO can accept an update (RUN state and not full)
//   i_port_free            predictor write port usable this cycle
//   i_flush_req            single-cycle request to clear the predictor
//   o_flush_busy           flush sequence in progress
//   o_pred_we / o_pred_*   write the FIFO head entry into the predictor
//   o_pred_clear[_index]   clear one predictor set during a flush
//   o_queue_count          current FIFO occupancy
// -----------------------------------------------------------------------------
module branch_pred_update_ctrl #(
  parameter int ADDR_WIDTH    = 64,
  parameter int QUEUE_DEPTH   = 4,
  parameter int FLUSH_ENTRIES = 64,
  parameter int CNT_W         = $clog2(QUEUE_DEPTH + 1),
  parameter int IDX_W         = $clog2(FLUSH_ENTRIES)
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_upd_valid,
  input  logic                  i_upd_taken,
  input  logic [1:0]            i_upd_way,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  output logic                  o_upd_ready,
  input  logic                  i_port_free,
  input  logic                  i_flush_req,
  output logic                  o_flush_busy,
  output logic                  o_pred_we,
  output logic                  o_pred_taken,
  output logic [1:0]            o_pred_way,
  output logic [ADDR_WIDTH-1:0] o_pred_pc,
  output logic [ADDR_WIDTH-1:0] o_pred_target,
  output logic                  o_pred_clear,
  output logic [IDX_W-1:0]      o_pred_clear_index,
  output logic [CNT_W-1:0]      o_queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic                  taken;
    logic [1:0]            way;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
  } upd_t;

  state_e           state_q, state_d;
  upd_t             mem_q [QUEUE_DEPTH];
  upd_t             head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] idx_q;

  logic push, pop, flush_start, idx_last;

  assign flush_start = (state_q == ST_RUN) && i_flush_req;
  assign idx_last    = (idx_q == IDX_W'(FLUSH_ENTRIES - 1));

  // A flush request in the same cycle wins over a push: the update is stale.
  assign push = i_upd_valid && o_upd_ready && !i_flush_req;
  assign pop  = o_pred_we;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk) begin
    if (i_arst) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (i_flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (idx_last && i_port_free) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    o_upd_ready  = 1'b0;
    o_pred_we    = 1'b0;
    o_flush_busy = 1'b0;
    o_pred_clear = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // Ready looks only at registered occupancy, never at this cycle's pop.
        o_upd_ready = (count_q < CNT_W'(QUEUE_DEPTH));
        o_pred_we   = (count_q != '0) && i_port_free && !i_flush_req;
      end
      ST_FLUSH: begin
        o_flush_busy = 1'b1;
        o_pred_clear = i_port_free;
      end
      default: ;
    endcase
  end

  assign head               = mem_q[rd_ptr_q];
  assign o_pred_taken       = head.taken;
  assign o_pred_way         = head.way;
  assign o_pred_pc          = head.pc;
  assign o_pred_target      = head.target;
  assign o_pred_clear_index = idx_q;
  assign o_queue_count      = count_q;

  // ---------------------------------------------------------------------------
  // Update FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage is reset because the head entry is visible on o_pred_*
  // at all times and must read as zero after reset; with only four entries the
  // reset cost is negligible. Deep RAM-style storage would normally skip it.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{taken: i_upd_taken, way: i_upd_way,
                           pc: i_upd_pc, target: i_upd_target};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and flush index
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
    end else begin
      if (flush_start) begin
        // Queued updates describe code that is being replaced; drop them all.
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        // Pointers are PTR_W bits wide, so they wrap modulo QUEUE_DEPTH.
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: ;
        endcase
      end

      // The walk only advances on cycles where a clear was actually issued.
      if (state_q == ST_FLUSH && i_port_free) begin
        idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_update_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for branch_pred_update_ctrl.
// The driver issues directed stimulus and keeps a small behavioural model of
// occupancy and flush progress. Every accepted update is pushed into a
// scoreboard queue; an independent monitor pops it whenever the DUT asserts
// o_pred_we and compares the presented fields. Flush clears are tallied per
// index by the monitor.
// -----------------------------------------------------------------------------
module tb_branch_pred_update_ctrl;

  localparam int AW = 64;
  localparam int QD = 4;
  localparam int FE = 64;

  typedef struct {
    logic          taken;
    logic [1:0]    way;
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
  } upd_t;

  logic          i_clk = 1'b0;
  logic          i_arst;
  logic          i_upd_valid, i_upd_taken;
  logic [1:0]    i_upd_way;
  logic [AW-1:0] i_upd_pc, i_upd_target;
  logic          o_upd_ready;
  logic          i_port_free, i_flush_req;
  logic          o_flush_busy, o_pred_we, o_pred_taken;
  logic [1:0]    o_pred_way;
  logic [AW-1:0] o_pred_pc, o_pred_target;
  logic          o_pred_clear;
  logic [5:0]    o_pred_clear_index;
  logic [2:0]    o_queue_count;

  branch_pred_update_ctrl #(
    .ADDR_WIDTH(AW), .QUEUE_DEPTH(QD), .FLUSH_ENTRIES(FE)
  ) dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_upd_valid(i_upd_valid), .i_upd_taken(i_upd_taken), .i_upd_way(i_upd_way),
    .i_upd_pc(i_upd_pc), .i_upd_target(i_upd_target), .o_upd_ready(o_upd_ready),
    .i_port_free(i_port_free), .i_flush_req(i_flush_req), .o_flush_busy(o_flush_busy),
    .o_pred_we(o_pred_we), .o_pred_taken(o_pred_taken), .o_pred_way(o_pred_way),
    .o_pred_pc(o_pred_pc), .o_pred_target(o_pred_target), .o_pred_clear(o_pred_clear),
    .o_pred_clear_index(o_pred_clear_index), .o_queue_count(o_queue_count)
  );

  always #5 i_clk = ~i_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  upd_t exp_q[$];
  int   clr_cnt = 0;
  int   hits[FE];

  // Behavioural model state, updated by the driver after each clock edge.
  bit   m_flush = 0;
  int   m_idx   = 0;
  int   m_count = 0;
  bit   last_accepted = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on every predictor write, tally clears.
  always @(negedge i_clk) begin
    if (!i_arst) begin
      check("we_and_clear_exclusive", 64'(o_pred_we & o_pred_clear), 64'd0);
      if (o_pred_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pred_we", 64'(o_pred_we), 64'd0);
        end else begin
          upd_t e;
          e = exp_q.pop_front();
          check("pred_pc",     o_pred_pc,            e.pc);
          check("pred_target", o_pred_target,        e.target);
          check("pred_taken",  64'(o_pred_taken),    64'(e.taken));
          check("pred_way",    64'(o_pred_way),      64'(e.way));
        end
      end
      if (o_pred_clear) begin
        clr_cnt++;
        hits[o_pred_clear_index]++;
      end
    end
  end

  // One clock cycle with the currently driven inputs.
  task automatic tick();
    bit   m_push, m_pop;
    upd_t u;
    @(negedge i_clk);
    m_pop  = !m_flush && m_count != 0 && i_port_free && !i_flush_req;
    m_push = !m_flush && i_upd_valid && m_count < QD && !i_flush_req;
    check("upd_ready",    64'(o_upd_ready),   64'(!m_flush && m_count < QD));
    check("queue_count",  64'(o_queue_count), 64'(m_count));
    check("flush_busy",   64'(o_flush_busy),  64'(m_flush));
    check("pred_we",      64'(o_pred_we),     64'(m_pop));
    check("pred_clear",   64'(o_pred_clear),  64'(m_flush && i_port_free));
    if (m_flush) check("clear_index", 64'(o_pred_clear_index), 64'(m_idx));
    u.taken = i_upd_taken; u.way = i_upd_way; u.pc = i_upd_pc; u.target = i_upd_target;
    @(posedge i_clk);
    last_accepted = m_push;
    if (!m_flush && i_flush_req) begin
      m_flush = 1; m_count = 0; exp_q.delete(); clr_cnt = 0;
      for (int i = 0; i < FE; i++) hits[i] = 0;
    end else if (m_flush) begin
      if (i_port_free) begin
        if (m_idx == FE - 1) begin m_flush = 0; m_idx = 0; end
        else m_idx++;
      end
    end else begin
      if (m_push) begin exp_q.push_back(u); m_count++; end
      if (m_pop) m_count--;
    end
    #1;
  endtask

  task automatic do_reset();
    i_arst = 1'b1;
    @(posedge i_clk);
    #1;
    i_arst = 1'b0;
    m_flush = 0; m_idx = 0; m_count = 0; exp_q.delete();
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic tk, input logic [1:0] way);
    int guard = 0;
    i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_target = pc + 64'h4000;
    i_upd_taken = tk; i_upd_way = way;
    do begin tick(); guard++; end while (!last_accepted && guard < 20);
    if (!last_accepted) check("push_timeout", 64'(guard), 64'd0);
    i_upd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    i_port_free = 1'b1;
    while (m_count != 0 && guard < 20) begin tick(); guard++; end
    check("drain_count", 64'(o_queue_count), 64'd0);
  endtask

  task automatic run_flush_to_end(input int budget);
    int guard = 0;
    while (m_flush && guard < budget) begin tick(); guard++; end
    check("flush_done_busy", 64'(o_flush_busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    i_arst = 1'b1; i_upd_valid = 1'b0; i_upd_taken = 1'b0; i_upd_way = 2'd0;
    i_upd_pc = '0; i_upd_target = '0; i_port_free = 1'b0; i_flush_req = 1'b0;
    for (int i = 0; i < FE; i++) hits[i] = 0;
    do_reset();

    // Reset state
    check("rst_ready", 64'(o_upd_ready),   64'd1);
    check("rst_count", 64'(o_queue_count), 64'd0);
    check("rst_busy",  64'(o_flush_busy),  64'd0);
    check("rst_we",    64'(o_pred_we),     64'd0);
    check("rst_clear", 64'(o_pred_clear),  64'd0);
    check("rst_pc",    o_pred_pc,          64'd0);

    // 1: three pushes held, then drained in order
    push(64'h100, 1'b1, 2'd0);
    push(64'h200, 1'b0, 2'd1);
    push(64'h300, 1'b1, 2'd2);
    tick();
    check("t1_count3", 64'(o_queue_count), 64'd3);
    check("t1_we_off", 64'(o_pred_we),     64'd0);
    i_port_free = 1'b1;
    tick(); tick(); tick();
    check("t1_empty", 64'(o_queue_count), 64'd0);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // 2: five back-to-back pushes against a stalled port
    i_port_free = 1'b0;
    for (int k = 0; k < 4; k++) push(64'h1000 + 64'(k) * 64'h10, k[0], 2'(k));
    i_upd_valid = 1'b1; i_upd_pc = 64'h1040; i_upd_target = 64'h5040;
    i_upd_taken = 1'b1; i_upd_way = 2'd3;
    tick(); tick();
    check("t2_full_count", 64'(o_queue_count), 64'd4);
    check("t2_full_ready", 64'(o_upd_ready),   64'd0);
    i_port_free = 1'b1;
    begin
      int guard = 0;
      do begin tick(); guard++; end while (!last_accepted && guard < 10);
      check("t2_fifth_accepted", 64'(last_accepted), 64'd1);
    end
    i_upd_valid = 1'b0;
    drain();

    // 3: fill, then steady push+pop, ten updates in total across pointer wrap
    i_port_free = 1'b0;
    for (int k = 0; k < 4; k++) push(64'h2000 + 64'(k) * 64'h8, k[1], 2'(k));
    check("t3_full", 64'(o_queue_count), 64'd4);
    i_port_free = 1'b1;
    for (int k = 4; k < 10; k++) begin
      push(64'h2000 + 64'(k) * 64'h8, k[1], 2'(k));
      if (k > 4) check("t3_steady_count", 64'(o_queue_count), 64'd3);
    end
    drain();

    // 4: flush with count=2 and a simultaneous push
    i_port_free = 1'b0;
    push(64'h3000, 1'b1, 2'd1);
    push(64'h3100, 1'b0, 2'd2);
    i_flush_req = 1'b1; i_upd_valid = 1'b1; i_upd_pc = 64'hdead;
    tick();
    i_flush_req = 1'b0; i_upd_valid = 1'b0;
    check("t4_count0", 64'(o_queue_count), 64'd0);
    check("t4_busy",   64'(o_flush_busy),  64'd1);
    check("t4_ready0", 64'(o_upd_ready),   64'd0);
    i_port_free = 1'b1;
    run_flush_to_end(100);
    check("t4_ready1",   64'(o_upd_ready), 64'd1);
    check("t4_clr_cnt",  64'(clr_cnt),     64'd64);
    tick(); tick();

    // 5: flush with port stalls every 3rd cycle and a repeated request
    i_flush_req = 1'b1;
    tick();
    i_flush_req = 1'b0;
    begin
      int  c = 0;
      bit  repulsed = 0;
      int  bad = 0;
      while (m_flush && c < 300) begin
        i_port_free = (c % 3 != 2);
        i_flush_req = (!repulsed && m_idx == 20);
        if (i_flush_req) repulsed = 1;
        tick();
        i_flush_req = 1'b0;
        c++;
      end
      check("t5_busy_end", 64'(o_flush_busy), 64'd0);
      check("t5_clr_cnt",  64'(clr_cnt),      64'd64);
      for (int i = 0; i < FE; i++) if (hits[i] != 1) bad++;
      check("t5_each_once", 64'(bad), 64'd0);
    end

    // 6: reset in the middle of a flush (and with data queued before it)
    i_port_free = 1'b0;
    push(64'h4000, 1'b1, 2'd0);
    i_flush_req = 1'b1;
    tick();
    i_flush_req = 1'b0;
    i_port_free = 1'b1;
    begin
      int guard = 0;
      while (m_idx != 30 && guard < 100) begin tick(); guard++; end
    end
    check("t6_at_idx30", 64'(o_pred_clear_index), 64'd30);
    do_reset();
    check("t6_busy",   64'(o_flush_busy),  64'd0);
    check("t6_clear",  64'(o_pred_clear),  64'd0);
    check("t6_count",  64'(o_queue_count), 64'd0);
    check("t6_ready",  64'(o_upd_ready),   64'd1);
    check("t6_index",  64'(o_pred_clear_index), 64'd0);
    check("t6_pc",     o_pred_pc,          64'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
